// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
// Optional build macro ZERO_REG_EN (hardwired-zero entry 0) is consumed by the RTL files.
package reg_file_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write bypass, data register and valid flag.
// With ZERO_REG_EN defined, address 0 always reads as zero.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] rd_next;

    // wr_ok is only ever set for in-range addresses, so a match implies rd_addr is in range
    always_comb begin
        rd_next = '0;
        if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_next = mem[rd_addr];
        end
        if (wr_ok && (wr_addr == rd_addr)) begin
            rd_next = wr_data;
        end
`ifdef ZERO_REG_EN
        if (rd_addr == '0) begin
            rd_next = '0;
        end
`endif
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: one write port, two registered read ports, sequenced clear engine.
// Build macro ZERO_REG_EN makes entry 0 a hardwired zero.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    output logic [WIDTH-1:0]  RdDataA,
    output logic              RdValidA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataB,
    output logic              RdValidB,
    input  logic              Clear,
    output logic              Busy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_ok;
    logic              rd_en_a;
    logic              rd_en_b;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Clear) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state == CLEAR);
        rd_en_a = (state == IDLE) && RdEnA;
        rd_en_b = (state == IDLE) && RdEnB;
`ifdef ZERO_REG_EN
        wr_ok   = (state == IDLE) && WrEn && ({1'b0, WrAddr} < DEPTH_L) && (WrAddr != '0);
`else
        wr_ok   = (state == IDLE) && WrEn && ({1'b0, WrAddr} < DEPTH_L);
`endif
    end

    // Counter sits at zero in IDLE, so entering CLEAR always starts from entry 0
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            clr_cnt <= '0;
        end else if ((state == IDLE) || (clr_cnt == LAST)) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[WrAddr] <= WrData;
        end
    end

    reg_file_rd_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_a (
        .Clk      (Clk),
        .nReset   (nReset),
        .rd_en    (rd_en_a),
        .rd_addr  (RdAddrA),
        .wr_ok    (wr_ok),
        .wr_addr  (WrAddr),
        .wr_data  (WrData),
        .mem      (mem),
        .rd_data  (RdDataA),
        .rd_valid (RdValidA)
    );

    reg_file_rd_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_b (
        .Clk      (Clk),
        .nReset   (nReset),
        .rd_en    (rd_en_b),
        .rd_addr  (RdAddrB),
        .wr_ok    (wr_ok),
        .wr_addr  (WrAddr),
        .wr_data  (WrData),
        .mem      (mem),
        .rd_data  (RdDataB),
        .rd_valid (RdValidB)
    );

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with one write port and two independent read ports (A, B). Successor to the single-port 8-entry register set; serves as the datapath register bank feeding the microprocessor ALU's two operands.
- Reads are registered: 1-cycle latency, with a valid flag per port.
- Same-cycle write-to-read bypass.
- Built-in sequenced clear engine that zeroes the bank one entry per cycle.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 8, number of entries (≥2; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
Clk  input  1  single clock, rising-edge
nReset  input  1  asynchronous, active-low reset
WrEn  input  1  write request
WrAddr  input  ADDR_W  write address
WrData  input  WIDTH  write data
RdEnA  input  1  port A read request
RdAddrA  input  ADDR_W  port A address
RdDataA  output  WIDTH  port A data (registered)
RdValidA  output  1  port A data valid, one-cycle pulse per accepted read
RdEnB  input  1  port B read request
RdAddrB  input  ADDR_W  port B address
RdDataB  output  WIDTH  port B data (registered)
RdValidB  output  1  port B data valid
Clear  input  1  start sequenced clear (level sampled at rising edge)
Busy  output  1  clear engine active

Behaviour:
Reset
- nReset low asynchronously sets:
  - all entries to 0
  - RdDataA/B to 0, RdValidA/B to 0
  - Busy to 0, FSM to IDLE, clear counter to 0
- Asserting reset mid-clear aborts the clear immediately; all entries are still zeroed by reset.

Write
- WrEn=1 in IDLE with WrAddr<DEPTH: entry[WrAddr] ← WrData at the rising edge.
- WrAddr≥DEPTH: write dropped, no side effects.

Read
- RdEnX=1 in IDLE: at the edge, RdDataX ← entry[RdAddrX] and RdValidX ← 1.
- RdEnX=0: RdValidX ← 0; RdDataX holds its previous value.
- RdAddrX≥DEPTH: RdDataX ← 0, RdValidX ← 1.
- Ports A and B are fully independent; both may address the same entry in the same cycle.

Bypass
- WrEn and RdEnX in the same cycle with WrAddr==RdAddrX (in range): RdDataX ← WrData (new value), not the stale entry.

Clear FSM
- States: IDLE, CLEAR.
- IDLE → CLEAR when Clear=1. Counter ← 0, Busy ← 1 at that edge.
- CLEAR: each cycle entry[counter] ← 0 and counter increments. After writing entry DEPTH-1, return to IDLE with Busy ← 0. Busy is high for exactly DEPTH cycles.
- In CLEAR, WrEn, RdEnA and RdEnB are ignored: no write, RdValidX ← 0, RdDataX holds.
- Clear asserted while already in CLEAR is ignored (no restart).
- Clear and WrEn in the same IDLE cycle: the write is performed, then the clear begins and wipes it.

Optional Feature:
Macro ZERO_REG_EN
- Defined: entry 0 is hardwired to zero. Writes to address 0 are dropped, reads of address 0 return 0, and bypass does not apply to address 0.
- Undefined: entry 0 is an ordinary storage entry.

Decomposition:
Shared package reg_file_pkg holds:
- FSM state encoding typedef (IDLE=1'b0, CLEAR=1'b1)
- default WIDTH/DEPTH constants
Sub-module: reg_file_rd_port. It is instantiated twice and contains the read register, valid flag, bypass mux and out-of-range handling for one port. The storage array, write logic and clear FSM stay in the top level.

Test Plan:
1. Reset, write entries 0..7 with 8'h55, 8'h0F, 8'h33, 8'h1D, 8'hAA, 8'hCC, 8'hE2, 8'hFF; then read A=i, B=7-i for each i → e.g. A=0 gives 8'h55 and B=7 gives 8'hFF, one cycle after request with RdValidA/B=1.
2. Same-cycle WrEn addr 3 data 8'h9C plus RdEnA addr 3 → RdDataA=8'h9C next cycle; entry 3 reads 8'h9C thereafter.
3. Fill all entries, pulse Clear → Busy high exactly 8 cycles; a WrEn of 8'h77 to addr 2 during Busy is dropped; reads after Busy falls return 0 for all entries.
4. Assert nReset mid-clear at counter=4 → Busy drops asynchronously; all entries read 0 after reset release; RdValidA/B=0 during reset.
5. DEPTH=6 build: write addr 7 is dropped; read addr 7 → RdData=0, RdValid=1.
6. With ZERO_REG_EN defined: write 8'hAB to addr 0, then read → 8'h00; same-cycle write/read at addr 0 → 8'h00.
